bit_serial_adder: RTL and testbench

//   Multi-bit adder built around one Full_Adder cell, used bit-serially, LSB first.
//   A carry flip-flop feeds C_out of each bit back into C_in of the next bit.

---
 rtl/bit_serial_adder_if.sv | 34 +++
 rtl/bit_serial_adder.sv | 101 ++++++++++
 tb/tb_bit_serial_adder.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/bit_serial_adder_if.sv
// Handshake and operand/result bundle for bit_serial_adder (master = requester, slave = adder).
// Latency: none; pure wiring between requester and adder.
// Backpressure: start is ignored while busy is high. Optional ovf port under BIT_SERIAL_ADDER_OVF_EN.
interface bit_serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] A_in;
  logic [WIDTH-1:0] B_in;
  logic             C_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Sum;
  logic             C_out;
`ifdef BIT_SERIAL_ADDER_OVF_EN
  logic             ovf;
`endif

  modport master (
    output start, A_in, B_in, C_in,
    input  busy, done, Sum, C_out
`ifdef BIT_SERIAL_ADDER_OVF_EN
    , input ovf
`endif
  );

  modport slave (
    input  start, A_in, B_in, C_in,
    output busy, done, Sum, C_out
`ifdef BIT_SERIAL_ADDER_OVF_EN
    , output ovf
`endif
  );
endinterface

// File: rtl/bit_serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell plus a carry flop, LSB first.
// Latency: start accepted at edge 0, done pulses in the cycle after edge WIDTH.
// Backpressure: start ignored while busy (SHIFT); BIT_SERIAL_ADDER_OVF_EN adds signed ovf.
module bit_serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  bit_serial_adder_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic [WIDTH-1:0] sum_q;
  logic [CNT_W-1:0] cnt_q;
  logic             carry_q;
  logic             c_out_q;
  logic             busy_q;
  logic             done_q;
`ifdef BIT_SERIAL_ADDER_OVF_EN
  logic             ovf_q;
`endif

  logic             s_d;
  logic             co_d;

  // Single full-adder cell fed by the operand LSBs and the carry flop.
  always_comb begin
    s_d  = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
    co_d = (a_sh_q[0] & b_sh_q[0]) | (carry_q & (a_sh_q[0] ^ b_sh_q[0]));
  end

  // Control FSM and datapath; IDLE and DONE both accept a new start, SHIFT ignores it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      c_out_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef BIT_SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        SHIFT: begin
          sum_q   <= {s_d, sum_q[WIDTH-1:1]};
          carry_q <= co_d;
          a_sh_q  <= {1'b0, a_sh_q[WIDTH-1:1]};
          b_sh_q  <= {1'b0, b_sh_q[WIDTH-1:1]};
          cnt_q   <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            // Final bit: carry_q is the carry into the MSB, co_d the carry out of it.
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            c_out_q <= co_d;
`ifdef BIT_SERIAL_ADDER_OVF_EN
            ovf_q   <= carry_q ^ co_d;
`endif
          end
        end
        default: begin
          if (bus.start) begin
            state_q <= SHIFT;
            busy_q  <= 1'b1;
            a_sh_q  <= bus.A_in;
            b_sh_q  <= bus.B_in;
            carry_q <= bus.C_in;
            cnt_q   <= '0;
            sum_q   <= '0;
            c_out_q <= 1'b0;
`ifdef BIT_SERIAL_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.Sum   = sum_q;
  assign bus.C_out = c_out_q;
`ifdef BIT_SERIAL_ADDER_OVF_EN
  assign bus.ovf   = ovf_q;
`endif
endmodule

// File: tb/tb_bit_serial_adder.sv
// Self-checking bench for bit_serial_adder at WIDTH=8 and WIDTH=2.
// Reference: {C_out,Sum} = A + B + C_in in plain integer arithmetic; signed ovf from operand/result signs.
// Define BIT_SERIAL_ADDER_OVF_EN to also check the ovf output.
module tb_bit_serial_adder;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  bit_serial_adder_if #(.WIDTH(8)) bus8 ();
  bit_serial_adder_if #(.WIDTH(2)) bus2 ();

  bit_serial_adder #(.WIDTH(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
  bit_serial_adder #(.WIDTH(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [8:0] ref_add(input logic [7:0] a, input logic [7:0] b, input logic c);
    int unsigned t;
    t = int'(a) + int'(b) + int'(c);
    return t[8:0];
  endfunction

  function automatic logic ref_ovf(input logic [7:0] a, input logic [7:0] b, input logic c);
    logic [8:0] r;
    r = ref_add(a, b, c);
    return (a[7] == b[7]) && (r[7] != a[7]);
  endfunction

  // Full transaction on the 8-bit DUT, with latency/busy/pulse checks.
  task automatic run_add8(input string tag, input logic [7:0] a, input logic [7:0] b, input logic c);
    logic [8:0] expv;
    int         k;
    int         busy_cnt;
    logic       seen;
    expv = ref_add(a, b, c);
    @(negedge clk);
    bus8.start = 1'b1; bus8.A_in = a; bus8.B_in = b; bus8.C_in = c;
    @(negedge clk);
    bus8.start = 1'b0;
    k = 0; busy_cnt = 0; seen = 1'b0;
    while (!seen && k < 20) begin
      if (bus8.done) seen = 1'b1;
      else begin
        if (bus8.busy) busy_cnt++;
        k++;
        bus8.A_in = 8'($urandom); bus8.B_in = 8'($urandom); bus8.C_in = 1'($urandom);
        @(negedge clk);
      end
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    chk({tag, "_latency"}, 32'(k), 32'd8);
    chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd8);
    chk({tag, "_sum"}, 32'(bus8.Sum), 32'(expv[7:0]));
    chk({tag, "_cout"}, 32'(bus8.C_out), 32'(expv[8]));
`ifdef BIT_SERIAL_ADDER_OVF_EN
    chk({tag, "_ovf"}, 32'(bus8.ovf), 32'(ref_ovf(a, b, c)));
`endif
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'(bus8.done), 32'd0);
    chk({tag, "_sum_hold"}, 32'(bus8.Sum), 32'(expv[7:0]));
  endtask

  // Short transaction on the 2-bit DUT.
  task automatic run_add2(input logic [1:0] a, input logic [1:0] b, input logic c);
    int unsigned expv;
    int          k;
    expv = int'(a) + int'(b) + int'(c);
    @(negedge clk);
    bus2.start = 1'b1; bus2.A_in = a; bus2.B_in = b; bus2.C_in = c;
    @(negedge clk);
    bus2.start = 1'b0;
    k = 0;
    while (!bus2.done && k < 10) begin
      k++;
      @(negedge clk);
    end
    chk("w2_latency", 32'(k), 32'd2);
    chk("w2_result", 32'({bus2.C_out, bus2.Sum}), expv);
  endtask

  initial begin
    logic [8:0] q[$];
    logic [8:0] e;
    logic [7:0] ra, rb;
    logic       rc;
    int         nres, last, k, dcount;

    checks = 0; errors = 0;
    rst_n = 1'b0;
    bus8.start = 1'b0; bus8.A_in = '0; bus8.B_in = '0; bus8.C_in = 1'b0;
    bus2.start = 1'b0; bus2.A_in = '0; bus2.B_in = '0; bus2.C_in = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(bus8.busy), 32'd0);
    chk("rst_done", 32'(bus8.done), 32'd0);
    chk("rst_sum", 32'(bus8.Sum), 32'd0);
    chk("rst_cout", 32'(bus8.C_out), 32'd0);
`ifdef BIT_SERIAL_ADDER_OVF_EN
    chk("rst_ovf", 32'(bus8.ovf), 32'd0);
`endif
    rst_n = 1'b1;

    // Directed vectors.
    run_add8("t1", 8'h5A, 8'h3C, 1'b0);
    run_add8("t2a", 8'hFF, 8'h01, 1'b0);
    run_add8("t2b", 8'hFF, 8'hFF, 1'b1);
    run_add8("t6a", 8'h7F, 8'h01, 1'b0);
    run_add8("t6b", 8'h80, 8'h80, 1'b0);

    // start during SHIFT must be ignored.
    @(negedge clk);
    bus8.start = 1'b1; bus8.A_in = 8'h10; bus8.B_in = 8'h20; bus8.C_in = 1'b0;
    @(negedge clk);
    bus8.start = 1'b0;
    repeat (2) @(negedge clk);
    bus8.start = 1'b1; bus8.A_in = 8'hAA; bus8.B_in = 8'h55; bus8.C_in = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    k = 0;
    while (!bus8.done && k < 20) begin k++; @(negedge clk); end
    chk("t3_done_seen", 32'(bus8.done), 32'd1);
    chk("t3_sum", 32'(bus8.Sum), 32'h30);
    chk("t3_cout", 32'(bus8.C_out), 32'd0);
    repeat (2) @(negedge clk);
    chk("t3_idle", 32'(bus8.busy), 32'd0);

    // Reset in the middle of SHIFT aborts the add.
    @(negedge clk);
    bus8.start = 1'b1; bus8.A_in = 8'hFF; bus8.B_in = 8'hFF; bus8.C_in = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("t4_busy_before", 32'(bus8.busy), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("t4_busy", 32'(bus8.busy), 32'd0);
    chk("t4_sum", 32'(bus8.Sum), 32'd0);
    chk("t4_cout", 32'(bus8.C_out), 32'd0);
    chk("t4_done", 32'(bus8.done), 32'd0);
    dcount = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus8.done) dcount++;
    end
    chk("t4_no_done", 32'(dcount), 32'd0);

    // Random single transactions.
    for (int i = 0; i < 20; i++) begin
      run_add8("rnd", 8'($urandom), 8'($urandom), 1'($urandom));
    end

    // Back-to-back with start held high; new operands presented only in DONE.
    @(negedge clk);
    ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
    bus8.start = 1'b1; bus8.A_in = ra; bus8.B_in = rb; bus8.C_in = rc;
    q.push_back(ref_add(ra, rb, rc));
    @(negedge clk);
    nres = 0; last = -1;
    for (int t = 0; t < 300 && nres < 10; t++) begin
      if (bus8.done) begin
        e = (q.size() > 0) ? q.pop_front() : 9'h1FF;
        chk("t5_result", 32'({bus8.C_out, bus8.Sum}), 32'(e));
        if (last >= 0) chk("t5_period", 32'(t - last), 32'd9);
        last = t;
        nres++;
        if (nres < 10) begin
          ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
          bus8.A_in = ra; bus8.B_in = rb; bus8.C_in = rc;
          q.push_back(ref_add(ra, rb, rc));
        end else begin
          bus8.start = 1'b0;
        end
      end else begin
        bus8.A_in = 8'($urandom); bus8.B_in = 8'($urandom); bus8.C_in = 1'($urandom);
      end
      @(negedge clk);
    end
    bus8.start = 1'b0;
    chk("t5_count", 32'(nres), 32'd10);

    // Exhaustive sweep on the 2-bit instance.
    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++)
        for (int c = 0; c < 2; c++)
          run_add2(2'(a), 2'(b), 1'(c));

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
